rename_reg_file: RTL and testbench

//  Architectural register file with per-register rename tags, between issue and the reorder buffer.
//  - On issue: reads rs1/rs2 as value-or-tag and renames rd to the newly allocated ROB tag.
//  - Forwards operands, op and imm to the ROB one cycle later.
//  - Consumes ROB commits (rd, tag, value).
//  - On misprediction: clears every rename tag.
//  - Tag 0 means "no producer / value valid". ROB tags run 1..2^ROB_BIT-1.

---
 rtl/rename_reg_file.sv | 130 +++++++++++++
 tb/tb_rename_reg_file.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - architectural register file with per-register rename tags.
// Optional debug read port: define RF_DBG_PORT_EN to add dbg_sel_i / dbg_val_o.
module rename_reg_file #(
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 5,
  parameter int DAT_W   = 32,
  parameter int OP_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mp_i,
  input  logic               is_en_i,
  input  logic [REG_BIT-1:0] is_rs1_i,
  input  logic [REG_BIT-1:0] is_rs2_i,
  input  logic [REG_BIT-1:0] is_rd_i,
  input  logic [ROB_BIT-1:0] is_qd_i,
  input  logic [OP_W-1:0]    is_op_i,
  input  logic [DAT_W-1:0]   is_imm_i,
  output logic               rf_en_o,
  output logic [ROB_BIT-1:0] rf_qj_o,
  output logic [ROB_BIT-1:0] rf_qk_o,
  output logic [DAT_W-1:0]   rf_vj_o,
  output logic [DAT_W-1:0]   rf_vk_o,
  output logic [ROB_BIT-1:0] rf_qd_o,
  output logic [OP_W-1:0]    rf_op_o,
  output logic [DAT_W-1:0]   rf_imm_o,
  input  logic               cmt_en_i,
  input  logic [REG_BIT-1:0] cmt_rd_i,
  input  logic [ROB_BIT-1:0] cmt_q_i,
  input  logic [DAT_W-1:0]   cmt_v_i
`ifdef RF_DBG_PORT_EN
  ,
  input  logic [REG_BIT-1:0] dbg_sel_i,
  output logic [DAT_W-1:0]   dbg_val_o
`endif
);

  localparam int NREG = 1 << REG_BIT;

  logic [DAT_W-1:0]   val [NREG];
  logic [ROB_BIT-1:0] tag [NREG];

  logic               cmt_wr;
  logic               ren;
  logic [ROB_BIT-1:0] qj_n, qk_n;
  logic [DAT_W-1:0]   vj_n, vk_n;

  assign cmt_wr = cmt_en_i && (cmt_rd_i != '0);
  assign ren    = is_en_i && (is_rd_i != '0);

  // A commit landing this cycle on the producer we would report is bypassed straight in.
  always_comb begin
    qj_n = '0;
    vj_n = '0;
    qk_n = '0;
    vk_n = '0;
    if (is_rs1_i != '0) begin
      if (cmt_en_i && cmt_rd_i == is_rs1_i && tag[is_rs1_i] == cmt_q_i) begin
        vj_n = cmt_v_i;
      end else begin
        qj_n = tag[is_rs1_i];
        vj_n = val[is_rs1_i];
      end
    end
    if (is_rs2_i != '0) begin
      if (cmt_en_i && cmt_rd_i == is_rs2_i && tag[is_rs2_i] == cmt_q_i) begin
        vk_n = cmt_v_i;
      end else begin
        qk_n = tag[is_rs2_i];
        vk_n = val[is_rs2_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
      rf_en_o  <= 1'b0;
      rf_qj_o  <= '0;
      rf_qk_o  <= '0;
      rf_vj_o  <= '0;
      rf_vk_o  <= '0;
      rf_qd_o  <= '0;
      rf_op_o  <= '0;
      rf_imm_o <= '0;
    end else if (mp_i) begin
      for (int i = 0; i < NREG; i++) begin
        tag[i] <= '0;
      end
      if (cmt_wr) begin
        val[cmt_rd_i] <= cmt_v_i;
      end
      rf_en_o <= 1'b0;
    end else if (en) begin
      if (cmt_wr) begin
        val[cmt_rd_i] <= cmt_v_i;
        // A same-cycle rename of this register carries the newer producer; keep it.
        if (tag[cmt_rd_i] == cmt_q_i && !(ren && is_rd_i == cmt_rd_i)) begin
          tag[cmt_rd_i] <= '0;
        end
      end
      if (ren) begin
        tag[is_rd_i] <= is_qd_i;
      end
      rf_en_o <= is_en_i;
      if (is_en_i) begin
        rf_qj_o  <= qj_n;
        rf_qk_o  <= qk_n;
        rf_vj_o  <= vj_n;
        rf_vk_o  <= vk_n;
        rf_qd_o  <= is_qd_i;
        rf_op_o  <= is_op_i;
        rf_imm_o <= is_imm_i;
      end
    end else begin
      rf_en_o <= 1'b0;
    end
  end

`ifdef RF_DBG_PORT_EN
  assign dbg_val_o = val[dbg_sel_i];
`else
  // No debug read port in this build.
`endif

endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - directed vector table plus randomized model check for rename_reg_file.
module tb_rename_reg_file;

  logic        clk = 1'b0;
  logic        rst, en, mp_i, is_en_i, cmt_en_i;
  logic [4:0]  is_rs1_i, is_rs2_i, is_rd_i, is_qd_i, cmt_rd_i, cmt_q_i;
  logic [5:0]  is_op_i;
  logic [31:0] is_imm_i, cmt_v_i;
  logic        rf_en_o;
  logic [4:0]  rf_qj_o, rf_qk_o, rf_qd_o;
  logic [31:0] rf_vj_o, rf_vk_o, rf_imm_o;
  logic [5:0]  rf_op_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rename_reg_file dut (
    .clk(clk), .rst(rst), .en(en), .mp_i(mp_i),
    .is_en_i(is_en_i), .is_rs1_i(is_rs1_i), .is_rs2_i(is_rs2_i), .is_rd_i(is_rd_i),
    .is_qd_i(is_qd_i), .is_op_i(is_op_i), .is_imm_i(is_imm_i),
    .rf_en_o(rf_en_o), .rf_qj_o(rf_qj_o), .rf_qk_o(rf_qk_o), .rf_vj_o(rf_vj_o),
    .rf_vk_o(rf_vk_o), .rf_qd_o(rf_qd_o), .rf_op_o(rf_op_o), .rf_imm_o(rf_imm_o),
    .cmt_en_i(cmt_en_i), .cmt_rd_i(cmt_rd_i), .cmt_q_i(cmt_q_i), .cmt_v_i(cmt_v_i)
  );

  typedef struct {
    logic        en, mp, is_en;
    logic [4:0]  rs1, rs2, rd, qd;
    logic        cmt_en;
    logic [4:0]  cmt_rd, cmt_q;
    logic [31:0] cmt_v;
    logic        e_en;
    logic [4:0]  e_qj;
    logic [31:0] e_vj;
    logic [4:0]  e_qk;
    logic [31:0] e_vk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en_, logic mp_, logic ise, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [4:0] qd, logic ce, logic [4:0] crd,
                              logic [4:0] cq, logic [31:0] cv, logic ee, logic [4:0] eqj,
                              logic [31:0] evj, logic [4:0] eqk, logic [31:0] evk);
    vec_t v;
    v.en = en_; v.mp = mp_; v.is_en = ise; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.qd = qd;
    v.cmt_en = ce; v.cmt_rd = crd; v.cmt_q = cq; v.cmt_v = cv;
    v.e_en = ee; v.e_qj = eqj; v.e_vj = evj; v.e_qk = eqk; v.e_vk = evk;
    return v;
  endfunction

  task automatic drive(vec_t v, logic [5:0] op, logic [31:0] imm);
    en = v.en; mp_i = v.mp; is_en_i = v.is_en;
    is_rs1_i = v.rs1; is_rs2_i = v.rs2; is_rd_i = v.rd; is_qd_i = v.qd;
    is_op_i = op; is_imm_i = imm;
    cmt_en_i = v.cmt_en; cmt_rd_i = v.cmt_rd; cmt_q_i = v.cmt_q; cmt_v_i = v.cmt_v;
  endtask

  task automatic check(string name, logic ee, logic [4:0] eqj, logic [31:0] evj, logic [4:0] eqk,
                       logic [31:0] evk, logic [4:0] eqd, logic [5:0] eop, logic [31:0] eimm);
    logic bad;
    n_vec++;
    bad = (rf_en_o !== ee);
    if (ee)
      bad = bad || (rf_qj_o !== eqj) || (rf_vj_o !== evj) || (rf_qk_o !== eqk) ||
            (rf_vk_o !== evk) || (rf_qd_o !== eqd) || (rf_op_o !== eop) || (rf_imm_o !== eimm);
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got en=%0b qj=%0d vj=%h qk=%0d vk=%h qd=%0d op=%0d imm=%h, want en=%0b qj=%0d vj=%h qk=%0d vk=%h qd=%0d op=%0d imm=%h",
               name, rf_en_o, rf_qj_o, rf_vj_o, rf_qk_o, rf_vk_o, rf_qd_o, rf_op_o, rf_imm_o,
               ee, eqj, evj, eqk, evk, eqd, eop, eimm);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), 6'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference state: plain arrays updated from the behavioural rules.
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  task automatic model_read(logic [4:0] rs, output logic [4:0] q, output logic [31:0] v);
    q = 0; v = 0;
    if (rs != 0) begin
      if (cmt_en_i && cmt_rd_i == rs && m_tag[rs] == cmt_q_i) v = cmt_v_i;
      else begin q = m_tag[rs]; v = m_val[rs]; end
    end
  endtask

  initial begin
    logic [4:0]  eqj, eqk, old_tag;
    logic [31:0] evj, evk;
    logic        ee;
    vec_t        r;

    do_reset();
    check("reset", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({rf_qj_o, rf_qk_o, rf_vj_o, rf_vk_o, rf_qd_o, rf_op_o, rf_imm_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got qj=%0d qk=%0d vj=%h vk=%h qd=%0d op=%0d imm=%h, want all 0",
               rf_qj_o, rf_qk_o, rf_vj_o, rf_vk_o, rf_qd_o, rf_op_o, rf_imm_o);
    end

    //            en mp is rs1 rs2 rd qd  ce crd cq cv          ee qj vj          qk vk
    vecs.push_back(mk(1,0,1, 3,0,5,7,   0,0,0,0,           1,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,3,0,8,   0,0,0,0,           1,7,0,           0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0,   1,5,7,32'h1234,    0,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,5,0,8,   0,0,0,0,           1,0,32'h1234,    0,32'h1234));
    vecs.push_back(mk(1,0,1, 0,0,5,7,   0,0,0,0,           1,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,5,0,10,  1,5,7,32'hAB,      1,0,32'hAB,      0,32'hAB));
    vecs.push_back(mk(1,0,1, 0,0,5,7,   0,0,0,0,           1,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,0,5,9,   1,5,7,32'hCD,      1,0,32'hCD,      0,0));
    vecs.push_back(mk(1,0,1, 5,0,0,1,   0,0,0,0,           1,9,32'hCD,      0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0,   1,5,7,32'h55,      0,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,0,0,1,   0,0,0,0,           1,9,32'h55,      0,0));
    vecs.push_back(mk(1,0,1, 0,0,4,3,   1,6,20,32'h66,     1,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 4,6,6,4,   0,0,0,0,           1,3,0,           0,32'h66));
    vecs.push_back(mk(1,1,1, 4,0,7,5,   1,4,3,32'h44,      0,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 4,6,0,1,   0,0,0,0,           1,0,32'h44,      0,32'h66));
    vecs.push_back(mk(1,0,1, 7,5,0,1,   0,0,0,0,           1,0,0,           0,32'h55));
    vecs.push_back(mk(1,0,1, 0,0,0,11,  1,0,0,32'hFF,      1,0,0,           0,0));
    vecs.push_back(mk(0,0,1, 0,0,5,12,  1,6,0,32'h77,      0,0,0,           0,0));
    vecs.push_back(mk(1,0,1, 5,6,0,1,   0,0,0,0,           1,0,32'h55,      0,32'h66));

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      drive(r, 6'(i + 1), 32'hC0DE_0000 + i);
      @(posedge clk);
      #1;
      check($sformatf("dir%0d", i), r.e_en, r.e_qj, r.e_vj, r.e_qk, r.e_vk, r.qd,
            6'(i + 1), 32'hC0DE_0000 + i);
    end

    do_reset();
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_tag[i] = 0; end
    for (int i = 0; i < 600; i++) begin
      mp_i     = ($urandom_range(0, 19) == 0);
      en       = mp_i || ($urandom_range(0, 9) != 0);
      is_en_i  = ($urandom_range(0, 9) < 7);
      is_rs1_i = 5'($urandom_range(0, 7));
      is_rs2_i = 5'($urandom_range(0, 7));
      is_rd_i  = 5'($urandom_range(0, 7));
      is_qd_i  = 5'($urandom_range(1, 31));
      is_op_i  = 6'($urandom);
      is_imm_i = $urandom;
      cmt_en_i = $urandom_range(0, 1);
      cmt_rd_i = 5'($urandom_range(0, 7));
      cmt_q_i  = (m_tag[cmt_rd_i] != 0 && $urandom_range(0, 3) != 0) ? m_tag[cmt_rd_i]
                                                                      : 5'($urandom_range(1, 31));
      cmt_v_i  = $urandom;

      model_read(is_rs1_i, eqj, evj);
      model_read(is_rs2_i, eqk, evk);
      ee = 0;
      if (mp_i) begin
        for (int k = 0; k < 32; k++) m_tag[k] = 0;
        if (cmt_en_i && cmt_rd_i != 0) m_val[cmt_rd_i] = cmt_v_i;
      end else if (en) begin
        ee = is_en_i;
        old_tag = m_tag[cmt_rd_i];
        if (cmt_en_i && cmt_rd_i != 0) begin
          m_val[cmt_rd_i] = cmt_v_i;
          if (old_tag == cmt_q_i) m_tag[cmt_rd_i] = 0;
        end
        if (is_en_i && is_rd_i != 0) m_tag[is_rd_i] = is_qd_i;
      end

      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", i), ee, eqj, evj, eqk, evk, is_qd_i, is_op_i, is_imm_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
